// File: rtl/kd_tree_query_scheduler.sv
// KD-tree query scheduler: loads the node set into the tree, issues query patches under
// result-FIFO credit control and returns leaf indices in issue order.
// Optional build macro KD_SCHED_PERF_CNT_EN adds perf_cycles / perf_stall counters.
module kd_tree_query_scheduler #(
   parameter int NUM_NODES      = 63,
   parameter int INTERNAL_WIDTH = 22,
   parameter int PATCH_WIDTH    = 55,
   parameter int ADDRESS_WIDTH  = 8,
   parameter int TREE_LATENCY   = 6,
   parameter int OUT_DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [15:0]               num_queries,
   input  logic                      node_valid,
   input  logic [INTERNAL_WIDTH-1:0] node_data,
   output logic                      node_ready,
   input  logic                      patch_valid,
   input  logic [PATCH_WIDTH-1:0]    patch_data,
   output logic                      patch_ready,
   output logic                      tree_fsm_enable,
   output logic                      tree_sender_enable,
   output logic [INTERNAL_WIDTH-1:0] tree_sender_data,
   output logic                      tree_patch_en,
   output logic [PATCH_WIDTH-1:0]    tree_patch,
   input  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index,
   input  logic                      tree_receiver_en,
   output logic                      out_valid,
   output logic [ADDRESS_WIDTH-1:0]  out_leaf,
   input  logic                      out_ready,
`ifdef KD_SCHED_PERF_CNT_EN
   output logic [31:0]               perf_cycles,
   output logic [31:0]               perf_stall,
`endif
   output logic                      busy,
   output logic                      done
);

   localparam int NODE_CW = $clog2(NUM_NODES + 1);
   localparam int PTR_W   = $clog2(OUT_DEPTH);
   localparam int CRED_W  = $clog2(OUT_DEPTH + 1);
   localparam logic [NODE_CW-1:0] LAST_NODE = NODE_CW'(NUM_NODES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_DRAIN} state_e;

   state_e              state_q, state_d;
   logic [15:0]         nq_q, nq_d;
   logic [NODE_CW-1:0]  node_cnt_q, node_cnt_d;
   logic [15:0]         issued_q, issued_d;
   logic [15:0]         popped_q, popped_d;
   logic [CRED_W-1:0]   credits_q, credits_d;
   logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
   logic [ADDRESS_WIDTH-1:0] fifo_mem [OUT_DEPTH];

   logic node_accept, patch_accept, push, pop, job_start;

   assign job_start          = (state_q == S_IDLE) && start;
   assign node_accept        = node_valid && node_ready;
   assign patch_accept       = patch_valid && patch_ready;
   assign tree_sender_enable = node_accept;
   assign tree_sender_data   = node_accept ? node_data : '0;
   assign tree_patch_en      = patch_accept;
   assign tree_patch         = patch_accept ? patch_data : '0;
   // Late tree results after a reset or job end land in IDLE and are dropped.
   assign push      = tree_receiver_en && (state_q != S_IDLE);
   assign out_valid = (wr_ptr_q != rd_ptr_q);
   assign pop       = out_valid && out_ready;
   assign out_leaf  = out_valid ? fifo_mem[rd_ptr_q[PTR_W-1:0]] : '0;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d         = state_q;
      node_ready      = 1'b0;
      tree_fsm_enable = 1'b0;
      patch_ready     = 1'b0;
      done            = 1'b0;
      busy            = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            tree_fsm_enable = 1'b1;
            node_ready      = 1'b1;
            if (node_valid && (node_cnt_q == LAST_NODE))
               state_d = (nq_q == 16'd0) ? S_DRAIN : S_SEARCH;
         end
         S_SEARCH: begin
            patch_ready = (issued_q < nq_q) && (credits_q != '0);
            if (patch_valid && patch_ready && ((issued_q + 16'd1) == nq_q))
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (popped_q == nq_q) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      nq_d       = job_start ? num_queries : nq_q;
      node_cnt_d = job_start ? '0 : node_cnt_q + NODE_CW'(node_accept);
      issued_d   = job_start ? '0 : issued_q + 16'(patch_accept);
      popped_d   = job_start ? '0 : popped_q + 16'(pop);
      credits_d  = credits_q;
      if (patch_accept && !pop)      credits_d = credits_q - CRED_W'(1);
      else if (!patch_accept && pop) credits_d = credits_q + CRED_W'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state_q    <= S_IDLE;
         nq_q       <= '0;
         node_cnt_q <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         credits_q  <= CRED_W'(OUT_DEPTH);
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         nq_q       <= nq_d;
         node_cnt_q <= node_cnt_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         credits_q  <= credits_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= tree_leaf_index;
   end

`ifdef KD_SCHED_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || job_start) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else begin
         if (busy) perf_cycles <= perf_cycles + 32'd1;
         if ((state_q == S_SEARCH) && patch_valid && !patch_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`else
   // Performance counters are absent in this build.
`endif

endmodule

// File: tb/tb_kd_tree_query_scheduler.sv
// Directed self-checking bench for kd_tree_query_scheduler with a fixed-latency tree stub.
module tb_kd_tree_query_scheduler;

   localparam int IW = 22;
   localparam int PW = 55;
   localparam int AW = 8;
   localparam int TL = 6;

   logic          clk = 1'b0;
   logic          rst_n, start, node_valid, patch_valid, out_ready;
   logic [15:0]   num_queries;
   logic [IW-1:0] node_data;
   logic [PW-1:0] patch_data;
   logic          node_ready, patch_ready, tree_fsm_enable, tree_sender_enable;
   logic [IW-1:0] tree_sender_data;
   logic          tree_patch_en;
   logic [PW-1:0] tree_patch;
   logic [AW-1:0] tree_leaf_index;
   logic          tree_receiver_en;
   logic          out_valid;
   logic [AW-1:0] out_leaf;
   logic          busy, done;
`ifdef KD_SCHED_PERF_CNT_EN
   logic [31:0]   perf_cycles, perf_stall;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int sender_cnt = 0;
   int patch_en_cnt = 0;
   int rx_cnt = 0;
   int first_acc, last_acc, first_valid, stalls;

   always #5 clk = ~clk;

   kd_tree_query_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_queries(num_queries),
      .node_valid(node_valid), .node_data(node_data), .node_ready(node_ready),
      .patch_valid(patch_valid), .patch_data(patch_data), .patch_ready(patch_ready),
      .tree_fsm_enable(tree_fsm_enable), .tree_sender_enable(tree_sender_enable),
      .tree_sender_data(tree_sender_data), .tree_patch_en(tree_patch_en),
      .tree_patch(tree_patch), .tree_leaf_index(tree_leaf_index),
      .tree_receiver_en(tree_receiver_en), .out_valid(out_valid), .out_leaf(out_leaf),
      .out_ready(out_ready),
`ifdef KD_SCHED_PERF_CNT_EN
      .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
      .busy(busy), .done(done)
   );

   // Tree stub: fixed TL-cycle pipeline, leaf = low patch byte xor 5A; not reset by rst_n.
   logic [TL-1:0] pv = '0;
   logic [AW-1:0] pl [TL];
   assign tree_receiver_en = pv[TL-1];
   assign tree_leaf_index  = pl[TL-1];

   always @(posedge clk) begin
      pv    <= {pv[TL-2:0], tree_patch_en};
      pl[0] <= tree_patch[7:0] ^ 8'h5A;
      for (int i = 1; i < TL; i++) pl[i] <= pl[i-1];
      if (tree_sender_enable) sender_cnt <= sender_cnt + 1;
      if (tree_patch_en)      patch_en_cnt <= patch_en_cnt + 1;
      if (tree_receiver_en)   rx_cnt <= rx_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] mk_patch(input int i);
      logic [PW-1:0] p;
      p[7:0]  = 8'(i * 3 + 7);
      p[54:8] = 47'(i * 1001) + 47'h1234_5678;
      return p;
   endfunction

   task automatic do_start(input int n);
      @(negedge clk);
      start = 1'b1;
      num_queries = 16'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Streams NUM_NODES nodes back-to-back; returns at the negedge after the last accept.
   task automatic load_nodes(input bit expect_search);
      int base;
      base = sender_cnt;
      for (int i = 0; i < 63; i++) begin
         node_valid = 1'b1;
         node_data  = IW'(i * 5 + 3);
         #1;
         if (i == 0) begin
            check("load_node_ready", node_ready, 1);
            check("load_fsm_en", tree_fsm_enable, 1);
            check("load_busy", busy, 1);
            check("load_sender_data", tree_sender_data, IW'(3));
         end
         @(negedge clk);
      end
      node_valid = 1'b0;
      #1;
      check("load_sender_pulses", sender_cnt - base, 63);
      check("load_exit_node_ready", node_ready, 0);
      check("load_exit_fsm_en", tree_fsm_enable, 0);
      check("load_exit_patch_ready", patch_ready, expect_search);
   endtask

   // hold=0: out_ready high throughout; otherwise out_ready rises on the hold-th stall cycle.
   task automatic run_search(input int n, input int hold);
      logic [AW-1:0] exp_q [$];
      int issued, got, cyc, pe_base;
      issued = 0; got = 0; cyc = 0; stalls = 0;
      first_acc = -1; last_acc = -1; first_valid = -1;
      pe_base = patch_en_cnt;
      out_ready = (hold == 0);
      while (got < n && cyc < 2000) begin
         patch_valid = (issued < n);
         patch_data  = mk_patch(issued);
         #1;
         if (patch_valid) begin
            if (patch_ready) begin
               if (issued == 0) check("issue_patch_bus", tree_patch, patch_data);
               exp_q.push_back(patch_data[7:0] ^ 8'h5A);
               if (first_acc < 0) first_acc = cyc;
               last_acc = cyc;
               issued++;
            end else begin
               stalls++;
               if (stalls == 1) check("credit_stop_after", issued, 8);
               if (!out_ready && stalls == hold) out_ready = 1'b1;
            end
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else check($sformatf("out_leaf_%0d", got), out_leaf, exp_q.pop_front());
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      patch_valid = 1'b0;
      out_ready   = 1'b0;
      #1;
      check("results_received", got, n);
      check("patch_en_pulses", patch_en_cnt - pe_base, n);
      check("done_after_last_pop", done, 1);
      @(negedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      int rx_base, late_out;
      rst_n = 1'b0; start = 1'b0; num_queries = '0;
      node_valid = 1'b0; node_data = '0;
      patch_valid = 1'b1; patch_data = mk_patch(9); out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_node_ready", node_ready, 0);
      check("rst_patch_ready", patch_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_tree_patch", tree_patch, 0);
      check("rst_sender_data", tree_sender_data, 0);
      patch_valid = 1'b0;
      rst_n = 1'b1;

      // Four queries, always-ready consumer: consecutive issue and minimum latency.
      do_start(4);
      load_nodes(1'b1);
      run_search(4, 0);
      check("issue_consecutive", last_acc - first_acc, 3);
      check("min_latency", first_valid - first_acc, TL + 1);

      // Twenty queries with a stalled consumer: credits stop issue after eight.
      do_start(20);
      load_nodes(1'b1);
      run_search(20, 5);
      check("stall_cycles_seen", stalls, 5);
`ifdef KD_SCHED_PERF_CNT_EN
      check("perf_stall", perf_stall, 5);
`endif

      // Zero queries: load, then straight to done.
      begin
         int pe0;
         pe0 = patch_en_cnt;
         do_start(0);
         load_nodes(1'b0);
         check("zero_q_done", done, 1);
         @(negedge clk);
         #1;
         check("zero_q_done_clear", done, 0);
         check("zero_q_idle", busy, 0);
         check("zero_q_no_patch", patch_en_cnt - pe0, 0);
      end

      // Reset mid-search with three queries in flight.
      do_start(10);
      load_nodes(1'b1);
      out_ready = 1'b0;
      rx_base = rx_cnt;
      for (int i = 0; i < 3; i++) begin
         patch_valid = 1'b1;
         patch_data  = mk_patch(i);
         @(negedge clk);
      end
      patch_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      late_out = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) late_out++;
      end
      check("late_rx_seen", rx_cnt - rx_base, 3);
      check("late_rx_no_output", late_out, 0);
      check("post_rst_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
